message_serializer: RTL and testbench

//  Streams fixed-format ASCII hex lines for debug and UART readout of minitest results (successor to the single-shot formatter).
//  - Each I_STB captures a COUNT x WIDTH-bit record into a DEPTH-entry FIFO.
//  - The record is emitted as "WWWW_WWWW..._WWWW\r\n", paced by TX_INTERVAL and by O_RDY backpressure.
//  - Sits between measurement logic and the UART transmitter.

---
 rtl/message_serializer_pkg.sv | 9 +
 rtl/message_serializer_if.sv | 9 +
 rtl/message_serializer_sync_fifo.sv | 28 ++
 rtl/message_serializer.sv | 90 +++++++++
 tb/tb_message_serializer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/message_serializer_pkg.sv
// message_serializer_pkg: ASCII constants, FSM state encoding and nibble-to-ASCII helper shared by the serializer.
// The SEQ_HI/SEQ_LO/COLON states are only reached when MSG_SERIALIZER_SEQNUM_EN is defined.
package message_serializer_pkg;
  localparam logic [7:0] CHR_CR = 8'h0D, CHR_LF = 8'h0A, CHR_SEP = 8'h5F, CHR_COLON = 8'h3A;
  typedef enum logic [2:0] {IDLE, SEQ_HI, SEQ_LO, COLON, DIGIT, SEP, CR, LF} state_t;
  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/message_serializer_if.sv
// message_serializer_if: record capture side and ASCII character stream side of the serializer.
interface message_serializer_if #(parameter int WIDTH = 32, parameter int COUNT = 2);
  logic rec_stb;
  logic [WIDTH*COUNT-1:0] rec_dat;
  logic full, ovf, rdy, stb;
  logic [7:0] dat;
  modport master(output rec_stb, rec_dat, rdy, input full, ovf, stb, dat);
  modport slave(input rec_stb, rec_dat, rdy, output full, ovf, stb, dat);
endinterface

// File: rtl/message_serializer_sync_fifo.sv
// sync_fifo: synchronous show-ahead FIFO; the caller only pushes when not full or when popping in the same cycle.
module sync_fifo #(parameter int WIDTH = 64, parameter int DEPTH = 4) (
  input  logic clk, rst, push, pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full, empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/message_serializer.sv
// message_serializer: queues records and streams each as a paced "WWWW_..._WWWW\r\n" ASCII hex line.
// Define MSG_SERIALIZER_SEQNUM_EN to prefix every line with a 2-digit hex sequence number and ':'.
module message_serializer import message_serializer_pkg::*; #(
  parameter int WIDTH = 32, COUNT = 2, DEPTH = 4, TX_INTERVAL = 4
) (
  input logic clk,
  input logic rst,
  message_serializer_if.slave bus
);
  localparam int D = WIDTH / 4;
  localparam int RW = WIDTH * COUNT;
  localparam int PW = TX_INTERVAL > 1 ? $clog2(TX_INTERVAL) : 1;
  localparam int NW = D > 1 ? $clog2(D) : 1;
  localparam int CW = COUNT > 1 ? $clog2(COUNT) : 1;
  state_t state, first;
  logic [RW-1:0] sh, head;
  logic [NW-1:0] nib;
  logic [CW-1:0] word;
  logic [PW-1:0] pace;
  logic empty, full, pop, emit, last_nib, last_word;
  logic [7:0] chr;
`ifdef MSG_SERIALIZER_SEQNUM_EN
  logic [7:0] seq;
  assign first = SEQ_HI;
`else
  assign first = DIGIT;
`endif
  assign emit = state != IDLE && pace == '0 && bus.rdy;
  // Popping on the LF emission lets the next line start with no idle gap.
  assign pop = !empty && (state == IDLE || (state == LF && emit));
  assign last_nib = nib == NW'(D - 1);
  assign last_word = word == CW'(COUNT - 1);
  assign bus.full = full;
  assign chr = state == CR ? CHR_CR : state == LF ? CHR_LF : state == SEP ? CHR_SEP :
`ifdef MSG_SERIALIZER_SEQNUM_EN
               state == COLON ? CHR_COLON : state == SEQ_HI ? hex_chr(seq[7:4]) :
               state == SEQ_LO ? hex_chr(seq[3:0]) :
`endif
               hex_chr(sh[RW-1 -: 4]);
  sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk, .rst, .push(bus.rec_stb && (!full || pop)), .pop,
    .din(bus.rec_dat), .dout(head), .full, .empty
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pace <= '0;
      sh <= '0;
      nib <= '0;
      word <= '0;
      bus.stb <= 1'b0;
      bus.dat <= 8'h00;
      bus.ovf <= 1'b0;
`ifdef MSG_SERIALIZER_SEQNUM_EN
      seq <= '0;
`endif
    end else begin
      bus.ovf <= bus.rec_stb && full && !pop;
      bus.stb <= emit;
      if (emit) bus.dat <= chr;
      pace <= emit ? PW'(TX_INTERVAL - 1) : pace == '0 ? pace : pace - 1'b1;
`ifdef MSG_SERIALIZER_SEQNUM_EN
      if (emit && state == LF) seq <= seq + 1'b1;
`endif
      if (pop) begin
        sh <= head;
        nib <= '0;
        word <= '0;
        state <= first;
      end else if (emit) begin
        case (state)
          SEQ_HI: state <= SEQ_LO;
          SEQ_LO: state <= COLON;
          COLON: state <= DIGIT;
          DIGIT: begin
            sh <= sh << 4;
            nib <= last_nib ? '0 : nib + 1'b1;
            state <= !last_nib ? DIGIT : last_word ? CR : SEP;
          end
          SEP: begin
            word <= word + 1'b1;
            state <= DIGIT;
          end
          CR: state <= LF;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_message_serializer.sv
// tb_message_serializer: directed checks of the hex line serializer; the prefix expectations follow MSG_SERIALIZER_SEQNUM_EN.
module tb_message_serializer;
  typedef struct {logic [63:0] rec; string body;} vec_t;
`ifdef MSG_SERIALIZER_SEQNUM_EN
  localparam int PFX = 3;
`else
  localparam int PFX = 0;
`endif
  localparam int LA = 19 + PFX, LB = 10 + PFX;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, pass = 0, total = 0, ovf_cnt = 0, ovf_cyc = -1;
  byte qa[$], qb[$];
  int ta[$], tq[$];
  vec_t tv[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  message_serializer_if #(.WIDTH(32), .COUNT(2)) a ();
  message_serializer_if #(.WIDTH(8), .COUNT(3)) b ();
  message_serializer #(.WIDTH(32), .COUNT(2), .DEPTH(2), .TX_INTERVAL(4)) dut_a (.clk(clk), .rst(rst), .bus(a));
  message_serializer #(.WIDTH(8), .COUNT(3), .DEPTH(4), .TX_INTERVAL(1)) dut_b (.clk(clk), .rst(rst), .bus(b));

  always @(negedge clk) begin
    if (a.stb) begin qa.push_back(a.dat); ta.push_back(cyc); end
    if (b.stb) begin qb.push_back(b.dat); tq.push_back(cyc); end
    if (a.ovf) begin ovf_cnt++; ovf_cyc = cyc; end
  end

  function automatic string line(int n, string body);
    string p = $sformatf("%02X:", n % 256);
`ifndef MSG_SERIALIZER_SEQNUM_EN
    p = "";
`endif
    return {p, body, "\r\n"};
  endfunction

  function automatic string grab(input byte q[$], input int s, input int n);
    string r = "";
    for (int i = s; i < s + n && i < q.size(); i++) r = $sformatf("%s%c", r, q[i]);
    return r;
  endfunction

  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      r = s[i] == 8'd13 ? {r, "<CR>"} : s[i] == 8'd10 ? {r, "<LF>"} : $sformatf("%s%c", r, s[i]);
    return r;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_s(string name, string act, string exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(act), vis(exp));
  endtask

  task automatic wait_a(int n, int lim);
    for (int i = 0; i < lim && qa.size() < n; i++) @(negedge clk);
    chk("char count a", qa.size(), n);
  endtask

  task automatic push_a(logic [63:0] rec);
    a.rec_stb = 1'b1;
    a.rec_dat = rec;
    @(negedge clk);
    a.rec_stb = 1'b0;
  endtask

  task automatic clear_a();
    qa.delete();
    ta.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad, t0;
    tv[0] = '{64'h01234567_ABCD4321, "01234567_ABCD4321"};
    tv[1] = '{64'h00000000_FFFFFFFF, "00000000_FFFFFFFF"};
    tv[2] = '{64'h89ABCDEF_76543210, "89ABCDEF_76543210"};
    tv[3] = '{64'hDEADBEEF_0BADF00D, "DEADBEEF_0BADF00D"};
    tv[4] = '{64'h11111111_22222222, "11111111_22222222"};
    tv[5] = '{64'h13579BDF_2468ACE0, "13579BDF_2468ACE0"};
    tv[6] = '{64'hFEDCBA98_01234567, "FEDCBA98_01234567"};
    tv[7] = '{64'h0F0F0F0F_F0F0F0F0, "0F0F0F0F_F0F0F0F0"};
    a.rec_stb = 1'b0; a.rec_dat = '0; a.rdy = 1'b1;
    b.rec_stb = 1'b0; b.rec_dat = '0; b.rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset stb", a.stb, 0);
    chk("reset dat", a.dat, 0);
    chk("reset ovf", a.ovf, 0);
    chk("reset full", a.full, 0);
    chk("reset stb b", b.stb, 0);

    // Single line, paced, plus the narrow unpaced instance on the same edge.
    while (cyc < 9) @(negedge clk);
    a.rec_stb = 1'b1; a.rec_dat = tv[0].rec;
    b.rec_stb = 1'b1; b.rec_dat = 24'hFF00A5;
    @(negedge clk);
    a.rec_stb = 1'b0; b.rec_stb = 1'b0;
    wait_a(LA, 2000);
    chk_s("line 1", grab(qa, 0, LA), line(0, tv[0].body));
    chk("first stb cycle", ta[0], 12);
    bad = 0;
    for (int i = 1; i < ta.size(); i++) if (ta[i] - ta[i-1] != 4) bad++;
    chk("spacing 4", bad, 0);
    chk("b char count", qb.size(), LB);
    chk_s("b line", grab(qb, 0, LB), line(0, "FF_00_A5"));
    chk("b first cycle", tq[0], 12);
    chk("b consecutive", tq[tq.size()-1] - tq[0], LB - 1);

    // Overflow on a depth-2 queue: fourth back-to-back record is dropped.
    repeat (10) @(negedge clk);
    clear_a();
    ovf_cnt = 0;
    t0 = cyc;
    for (int i = 1; i <= 4; i++) begin
      a.rec_stb = 1'b1; a.rec_dat = tv[i].rec;
      @(negedge clk);
      if (i == 2) chk("full after 2nd", a.full, 0);
      if (i == 3) chk("full after 3rd", a.full, 1);
    end
    a.rec_stb = 1'b0;
    wait_a(3 * LA, 2000);
    for (int i = 0; i < 3; i++) chk_s($sformatf("ovf line %0d", i), grab(qa, i * LA, LA), line(1 + i, tv[1 + i].body));
    repeat (20) @(negedge clk);
    chk("extra chars after drop", qa.size(), 3 * LA);
    chk("ovf pulses", ovf_cnt, 1);
    chk("ovf cycle", ovf_cyc, t0 + 4);
    chk("full drained", a.full, 0);

    // Backpressure stall after the 5th character.
    clear_a();
    push_a(tv[5].rec);
    wait_a(5, 500);
    a.rdy = 1'b0;
    repeat (50) @(negedge clk);
    chk("no chars in stall", qa.size(), 5);
    a.rdy = 1'b1;
    wait_a(LA, 2000);
    chk_s("stalled line", grab(qa, 0, LA), line(4, tv[5].body));
    chk("resume gap", ta[5] - ta[4] >= 50, 1);

    // Reset mid-line abandons it; a fresh record gives a fresh line.
    clear_a();
    push_a(tv[6].rec);
    wait_a(8, 500);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no chars after rst", qa.size(), 8);
    chk("full after rst", a.full, 0);
    chk("stb after rst", a.stb, 0);
    chk("dat after rst", a.dat, 0);
    push_a(tv[7].rec);
    wait_a(8 + LA, 2000);
    chk_s("fresh line", grab(qa, 8, LA), line(0, tv[7].body));

`ifdef MSG_SERIALIZER_SEQNUM_EN
    // Sequence number wraps FF -> 00 across 257 lines.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_a();
    ovf_cnt = 0;
    for (int r = 0; r < 257; r++) begin
      for (int i = 0; i < 1000 && a.full; i++) @(negedge clk);
      push_a({32'(r), 32'(r * 7)});
    end
    wait_a(257 * LA, 30000);
    bad = 0;
    for (int r = 0; r < 257; r++)
      if (grab(qa, r * LA, LA) != line(r, $sformatf("%08X_%08X", r, r * 7))) bad++;
    chk("257 lines", bad, 0);
    chk_s("prefix 255", grab(qa, 255 * LA, 3), "FF:");
    chk_s("prefix 256", grab(qa, 256 * LA, 3), "00:");
    chk("seq ovf", ovf_cnt, 0);
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
